// File: rtl/load_align_unit.sv
// load_align_unit: tracks loads between LSU request and memory response,
// aligns/extends the returned word and queues results for writeback in order.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_memop, i_req_index, i_req_rd
//                       LSU request handshake and access description
//   i_rsp_valid, i_rsp_data
//                       memory read word (no back-pressure)
//   o_wb_valid/i_wb_ready, o_wb_data, o_wb_rd
//                       writeback handshake and extended result
//   o_misaligned        one-cycle pulse after a misaligned load is rejected
//   o_orphan            one-cycle pulse after a response with nothing pending

package load_align_pkg;
  typedef enum logic [3:0] {
    memop_none     = 4'd0,
    memop_l_byte   = 4'd1,
    memop_l_ubyte  = 4'd2,
    memop_l_hword  = 4'd3,
    memop_l_uhword = 4'd4,
    memop_l_word   = 4'd5,
    memop_s_byte   = 4'd6,
    memop_s_hword  = 4'd7,
    memop_s_word   = 4'd8
  } rv32_memop;
endpackage

module load_align_unit
  import load_align_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  rv32_memop   i_req_memop,
  input  logic [1:0]  i_req_index,
  input  logic [4:0]  i_req_rd,
  input  logic        i_rsp_valid,
  input  logic [31:0] i_rsp_data,
  output logic        o_wb_valid,
  input  logic        i_wb_ready,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_rd,
  output logic        o_misaligned,
  output logic        o_orphan
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(DEPTH);

  typedef struct packed {
    rv32_memop  memop;
    logic [1:0] index;
    logic [4:0] rd;
  } pend_t;

  pend_t       pend_mem     [DEPTH];
  logic [31:0] res_data_mem [DEPTH];
  logic [4:0]  res_rd_mem   [DEPTH];

  logic [PW-1:0] pend_wr, pend_rd, res_wr, res_rd;
  logic [CW-1:0] pend_cnt, res_cnt;

  logic        req_fire, is_load, aligned;
  logic        pend_push, mis_fire, rsp_pop, orphan_fire, wb_pop;
  pend_t       head;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_result;

  // Ready is a function of registered occupancy only, so a writeback pop
  // in the current cycle cannot admit a new request in the same cycle.
  assign o_req_ready = ({1'b0, pend_cnt} + {1'b0, res_cnt}) < DEPTH_LIM;
  assign o_wb_valid  = (res_cnt != '0);
  assign o_wb_data   = o_wb_valid ? res_data_mem[res_rd] : '0;
  assign o_wb_rd     = o_wb_valid ? res_rd_mem[res_rd]   : '0;

  assign req_fire    = i_req_valid & o_req_ready;
  assign pend_push   = req_fire & is_load & aligned;
  assign mis_fire    = req_fire & is_load & ~aligned;
  assign rsp_pop     = i_rsp_valid & (pend_cnt != '0);
  assign orphan_fire = i_rsp_valid & (pend_cnt == '0);
  assign wb_pop      = o_wb_valid & i_wb_ready;
  assign head        = pend_mem[pend_rd];

  always_comb begin
    is_load = 1'b0;
    aligned = 1'b1;
    unique case (i_req_memop)
      memop_l_byte, memop_l_ubyte: is_load = 1'b1;
      memop_l_hword, memop_l_uhword: begin
        is_load = 1'b1;
        aligned = ~i_req_index[0];
      end
      memop_l_word: begin
        is_load = 1'b1;
        aligned = (i_req_index == 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = '0;
    unique case (head.index)
      2'd0: byte_sel = i_rsp_data[7:0];
      2'd1: byte_sel = i_rsp_data[15:8];
      2'd2: byte_sel = i_rsp_data[23:16];
      2'd3: byte_sel = i_rsp_data[31:24];
      default: ;
    endcase
    half_sel    = head.index[1] ? i_rsp_data[31:16] : i_rsp_data[15:0];
    load_result = i_rsp_data;
    unique case (head.memop)
      memop_l_byte:   load_result = {{24{byte_sel[7]}}, byte_sel};
      memop_l_ubyte:  load_result = {24'd0, byte_sel};
      memop_l_hword:  load_result = {{16{half_sel[15]}}, half_sel};
      memop_l_uhword: load_result = {16'd0, half_sel};
      default:        load_result = i_rsp_data;
    endcase
  end

  // Storage arrays carry no reset; validity is governed by the counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (pend_push) pend_mem[pend_wr] <= '{memop: i_req_memop, index: i_req_index, rd: i_req_rd};
      if (rsp_pop) begin
        res_data_mem[res_wr] <= load_result;
        res_rd_mem[res_wr]   <= head.rd;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_wr      <= '0;
      pend_rd      <= '0;
      res_wr       <= '0;
      res_rd       <= '0;
      pend_cnt     <= '0;
      res_cnt      <= '0;
      o_misaligned <= 1'b0;
      o_orphan     <= 1'b0;
    end else begin
      if (pend_push) pend_wr <= (pend_wr == LAST_PTR) ? '0 : pend_wr + 1'b1;
      if (rsp_pop) begin
        pend_rd <= (pend_rd == LAST_PTR) ? '0 : pend_rd + 1'b1;
        res_wr  <= (res_wr == LAST_PTR) ? '0 : res_wr + 1'b1;
      end
      if (wb_pop) res_rd <= (res_rd == LAST_PTR) ? '0 : res_rd + 1'b1;
      pend_cnt     <= pend_cnt + CW'(pend_push) - CW'(rsp_pop);
      res_cnt      <= res_cnt + CW'(rsp_pop) - CW'(wb_pop);
      o_misaligned <= mis_fire;
      o_orphan     <= orphan_fire;
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit (DEPTH=2): directed cases followed
// by randomized traffic, all compared against a queue-based reference model.

module tb_load_align_unit;
  import load_align_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, rsp_valid, wb_valid, wb_ready;
  rv32_memop   req_memop;
  logic [1:0]  req_index;
  logic [4:0]  req_rd, wb_rd;
  logic [31:0] rsp_data, wb_data;
  logic        misaligned, orphan;

  always #5 clk = ~clk;

  load_align_unit #(.DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_memop  (req_memop),
    .i_req_index  (req_index),
    .i_req_rd     (req_rd),
    .i_rsp_valid  (rsp_valid),
    .i_rsp_data   (rsp_data),
    .o_wb_valid   (wb_valid),
    .i_wb_ready   (wb_ready),
    .o_wb_data    (wb_data),
    .o_wb_rd      (wb_rd),
    .o_misaligned (misaligned),
    .o_orphan     (orphan)
  );

  typedef struct {
    rv32_memop  op;
    logic [1:0] idx;
    logic [4:0] rd;
  } pend_e;
  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } res_e;

  pend_e pend_q[$];
  res_e  res_q[$];
  bit    exp_mis, exp_orph;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int access_size(rv32_memop op);
    case (op)
      memop_l_byte, memop_l_ubyte:   return 1;
      memop_l_hword, memop_l_uhword: return 2;
      memop_l_word:                  return 4;
      default:                       return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(rv32_memop op, logic [1:0] idx, logic [31:0] w);
    int unsigned i, b, h;
    i = idx;
    b = (w >> (8 * i)) & 32'hFF;
    h = (w >> (16 * (i / 2))) & 32'hFFFF;
    case (op)
      memop_l_byte:   return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      memop_l_ubyte:  return b;
      memop_l_hword:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      memop_l_uhword: return h;
      default:        return w;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model across the coming edge,
  // then compare every output just after that edge.
  task automatic step(input logic r, input logic rv, input rv32_memop op, input logic [1:0] idx,
                      input logic [4:0] rd, input logic sv, input logic [31:0] sd, input logic wr);
    int  sz;
    bit  ready, acc, pop_wb;
    rst = r; req_valid = rv; req_memop = op; req_index = idx; req_rd = rd;
    rsp_valid = sv; rsp_data = sd; wb_ready = wr;
    if (r) begin
      pend_q.delete();
      res_q.delete();
      exp_mis  = 0;
      exp_orph = 0;
    end else begin
      ready  = (pend_q.size() + res_q.size()) < DEPTH;
      acc    = rv && ready;
      pop_wb = (res_q.size() > 0) && wr;
      sz     = access_size(op);
      exp_mis  = 0;
      exp_orph = 0;
      if (pop_wb) void'(res_q.pop_front());
      if (sv) begin
        if (pend_q.size() > 0) begin
          pend_e e;
          e = pend_q.pop_front();
          res_q.push_back('{data: ref_load(e.op, e.idx, sd), rd: e.rd});
        end else exp_orph = 1;
      end
      if (acc && sz != 0) begin
        if ((int'(idx) % sz) == 0) pend_q.push_back('{op: op, idx: idx, rd: rd});
        else exp_mis = 1;
      end
    end
    @(posedge clk);
    #1;
    check("req_ready", 32'(req_ready), 32'((pend_q.size() + res_q.size()) < DEPTH));
    check("wb_valid", 32'(wb_valid), 32'(res_q.size() > 0));
    check("wb_data", wb_data, (res_q.size() > 0) ? res_q[0].data : 32'd0);
    check("wb_rd", 32'(wb_rd), (res_q.size() > 0) ? 32'(res_q[0].rd) : 32'd0);
    check("misaligned", 32'(misaligned), 32'(exp_mis));
    check("orphan", 32'(orphan), 32'(exp_orph));
  endtask

  task automatic idle(input logic wr);
    step(1'b0, 1'b0, memop_none, 2'd0, 5'd0, 1'b0, 32'd0, wr);
  endtask

  task automatic req(input rv32_memop op, input logic [1:0] idx, input logic [4:0] rd, input logic wr);
    step(1'b0, 1'b1, op, idx, rd, 1'b0, 32'd0, wr);
  endtask

  task automatic rsp(input logic [31:0] d, input logic wr);
    step(1'b0, 1'b0, memop_none, 2'd0, 5'd0, 1'b1, d, wr);
  endtask

  initial begin
    // reset state
    step(1'b1, 1'b0, memop_none, 2'd0, 5'd0, 1'b0, 32'd0, 1'b1);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_wb_data", wb_data, 32'd0);

    // byte loads, signed then unsigned
    req(memop_l_byte, 2'd2, 5'd5, 1'b1);
    rsp(32'h1280_3456, 1'b1);
    check("lb_data", wb_data, 32'hFFFF_FF80);
    check("lb_rd", 32'(wb_rd), 32'd5);
    idle(1'b1);
    req(memop_l_ubyte, 2'd2, 5'd5, 1'b1);
    rsp(32'h1280_3456, 1'b1);
    check("lbu_data", wb_data, 32'h0000_0080);
    idle(1'b1);

    // halfword loads
    req(memop_l_hword, 2'd2, 5'd7, 1'b1);
    rsp(32'h8001_0000, 1'b1);
    check("lh_data", wb_data, 32'hFFFF_8001);
    idle(1'b1);
    req(memop_l_uhword, 2'd0, 5'd8, 1'b1);
    rsp(32'h0000_F00F, 1'b1);
    check("lhu_data", wb_data, 32'h0000_F00F);
    idle(1'b1);

    // misaligned and store traffic
    req(memop_l_word, 2'd1, 5'd3, 1'b1);
    check("lw_mis", 32'(misaligned), 32'd1);
    idle(1'b1);
    check("lw_mis_clear", 32'(misaligned), 32'd0);
    req(memop_l_hword, 2'd3, 5'd3, 1'b1);
    idle(1'b1);
    req(memop_s_word, 2'd0, 5'd0, 1'b1);
    idle(1'b1);

    // fill to DEPTH with writeback stalled, then drain back-to-back
    req(memop_l_word, 2'd0, 5'd10, 1'b0);
    req(memop_l_ubyte, 2'd3, 5'd11, 1'b0);
    check("full_ready", 32'(req_ready), 32'd0);
    rsp(32'hDEAD_BEEF, 1'b0);
    rsp(32'hAB00_0000, 1'b0);
    idle(1'b0);
    check("hold_data", wb_data, 32'hDEAD_BEEF);
    idle(1'b1);
    check("drain2_data", wb_data, 32'h0000_00AB);
    idle(1'b1);
    check("drained_ready", 32'(req_ready), 32'd1);

    // orphan response, then reset with loads pending
    rsp(32'h1234_5678, 1'b1);
    check("orphan_pulse", 32'(orphan), 32'd1);
    req(memop_l_word, 2'd0, 5'd1, 1'b1);
    req(memop_l_word, 2'd0, 5'd2, 1'b1);
    step(1'b1, 1'b0, memop_none, 2'd0, 5'd0, 1'b0, 32'd0, 1'b1);
    rsp(32'h5555_5555, 1'b1);

    // request, response and writeback pop in one cycle
    req(memop_l_word, 2'd0, 5'd20, 1'b0);
    rsp(32'h0000_0001, 1'b0);
    step(1'b0, 1'b1, memop_l_word, 2'd0, 5'd21, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, memop_l_word, 2'd0, 5'd22, 1'b1, 32'h0000_0002, 1'b1);
    step(1'b0, 1'b1, memop_l_word, 2'd0, 5'd23, 1'b1, 32'h0000_0003, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic sv;
      sv = ($urandom_range(0, 3) != 0) ? (pend_q.size() > 0) : 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
           rv32_memop'($urandom_range(0, 8)), 2'($urandom), 5'($urandom),
           sv, $urandom, 1'($urandom_range(0, 9) < 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
